stopwatch_ctrl: RTL

Control sequencer for the stopwatch counter datapath. It conditions the pause and clear buttons and the sel/adj switches, runs the RUN/PAUSE/ADJUST mode state machine, and issues one-cycle increment and clear strobes to the minutes:seconds counters from the 1 Hz and 2 Hz tick enables. It also drives blink qualifiers to the 7-segment scan logic so the field being adjusted flashes.

---
 rtl/stopwatch_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control sequencer for the stopwatch minutes:seconds datapath.
// Conditions the buttons and switches, runs the RUN/PAUSE/ADJUST mode machine, and
// issues one-cycle increment/clear strobes plus blink qualifiers for the display.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pause_btn, clr_btn  raw bouncing pushbuttons (synchronized + debounced)
//   sel, adj            raw switches (synchronized only); sel=1 picks minutes, adj=1 adjust
//   tick_1hz, tick_2hz  one-cycle tick enables
//   sec_wrap            datapath seconds counter is at 59
//   sec_inc, min_inc    one-cycle increment strobes
//   clr_cnt             one-cycle clear strobe
//   paused              pause flag level
//   adjusting           high while in ADJUST
//   blink_sec/min       blank the seconds/minutes digits this cycle
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pause_btn,
    input  logic clr_btn,
    input  logic sel,
    input  logic adj,
    input  logic tick_1hz,
    input  logic tick_2hz,
    input  logic sec_wrap,
    output logic sec_inc,
    output logic min_inc,
    output logic clr_cnt,
    output logic paused,
    output logic adjusting,
    output logic blink_sec,
    output logic blink_min
);

    typedef enum logic [1:0] {StRun, StPause, StAdjust} state_t;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Raw input bit order: 0 pause_btn, 1 clr_btn, 2 sel, 3 adj
    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [1:0]       db_stable;
    logic [1:0]       db_prev;
    logic [CNT_W-1:0] db_cnt [2];

    state_t state;
    state_t state_nxt;
    logic   phase;
    logic   phase_nxt;
    logic   sec_nxt;
    logic   min_nxt;
    logic   pause_press;
    logic   clr_press;
    logic   sel_s;
    logic   adj_s;

    assign raw         = {adj, sel, clr_btn, pause_btn};
    assign sel_s       = sync2[2];
    assign adj_s       = sync2[3];
    // Press pulse is valid in the cycle after stable rises; it acts on the following edge.
    assign pause_press = db_stable[0] & ~db_prev[0];
    assign clr_press   = db_stable[1] & ~db_prev[1];

    always_comb begin
        state_nxt = state;
        unique case (state)
            StRun: begin
                if (adj_s)       state_nxt = StAdjust;
                else if (paused) state_nxt = StPause;
            end
            StPause: begin
                if (adj_s)        state_nxt = StAdjust;
                else if (!paused) state_nxt = StRun;
            end
            StAdjust: begin
                if (!adj_s) state_nxt = paused ? StPause : StRun;
            end
            default: state_nxt = StRun;
        endcase

        // Strobes follow the state being left, so a tick on a transition uses the old mode.
        sec_nxt = 1'b0;
        min_nxt = 1'b0;
        if (state == StRun && tick_1hz) begin
            sec_nxt = 1'b1;
            min_nxt = sec_wrap;
        end else if (state == StAdjust && tick_2hz) begin
            sec_nxt = ~sel_s;
            min_nxt = sel_s;
        end
        if (clr_press) begin
            sec_nxt = 1'b0;
            min_nxt = 1'b0;
        end

        if (state_nxt != StAdjust) begin
            phase_nxt = 1'b0;
        end else if (state == StAdjust && tick_2hz) begin
            phase_nxt = ~phase;
        end else begin
            phase_nxt = phase;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            db_stable <= '0;
            db_prev   <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
            state     <= StRun;
            phase     <= 1'b0;
            paused    <= 1'b0;
            sec_inc   <= 1'b0;
            min_inc   <= 1'b0;
            clr_cnt   <= 1'b0;
            adjusting <= 1'b0;
            blink_sec <= 1'b0;
            blink_min <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                db_prev[i] <= db_stable[i];
                if (sync2[i] == db_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CntLast) begin
                    db_stable[i] <= sync2[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
            state     <= state_nxt;
            phase     <= phase_nxt;
            paused    <= paused ^ pause_press;
            sec_inc   <= sec_nxt;
            min_inc   <= min_nxt;
            clr_cnt   <= clr_press;
            adjusting <= (state_nxt == StAdjust);
            blink_sec <= (state_nxt == StAdjust) & ~sel_s & phase_nxt;
            blink_min <= (state_nxt == StAdjust) & sel_s & phase_nxt;
        end
    end

endmodule
